// File: rtl/bolt_pkg.sv
// bolt_pkg: shared widths, NOP encoding and fetch entry layout for the front end
package bolt_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO with synchronous flush taking priority over push/pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push_ok, pop_ok;
    always_comb begin
        full     = count_q == CW'(DEPTH);
        empty    = count_q == '0;
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push_ok);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop_ok);
        count_d  = flush ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
        rdata    = mem_q[rd_ptr_q];
        count    = count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // storage is validated by count, so it needs no reset
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch-to-decode queue with misalign tagging, NOP substitution and redirect flush
module fetch_buffer
    import bolt_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_misalign,
    output logic [CW-1:0]   count_o
);
    fetch_entry_t wr_entry, head;
    logic push, pop, full, empty;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count_o),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        wr_entry     = '{pc: in_pc, instr: in_instr, misalign: in_pc[1:0] != 2'b00};
        in_ready     = ~full & ~flush_i;
        out_valid    = ~empty;
        push         = in_valid & in_ready;
        pop          = out_valid & out_ready;
        // when empty, pc holds the last head shown rather than stale storage
        out_pc       = out_valid ? head.pc : last_pc_q;
        out_instr    = out_valid ? head.instr : NOP_INSTR;
        out_misalign = out_valid & head.misalign;
        last_pc_d    = out_pc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_pc_q <= '0;
        else        last_pc_q <= last_pc_d;
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_fetch_buffer;
    import bolt_pkg::*;
    logic clk = 0, rst_n = 0, flush_i = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, out_misalign;
    logic [31:0] in_pc = 0, in_instr = 0, out_pc, out_instr;
    logic [2:0] count_o;
    fetch_entry_t exp_q [$];
    int checks = 0, failures = 0;

    fetch_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_misalign(out_misalign), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic mis);
        in_valid = 1;
        in_pc    = pc;
        in_instr = instr;
        exp_q.push_back('{pc: pc, instr: instr, misalign: mis});
        step();
    endtask

    // monitor: every accepted pop must match the oldest expected entry
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !flush_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", out_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", out_pc, e.pc);
                    chk("pop_instr", out_instr, e.instr);
                    chk("pop_misalign", 32'(out_misalign), 32'(e.misalign));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_out_instr", out_instr, 32'h13);
        chk("rst_out_pc", out_pc, 0);
        #10 rst_n = 1;
        step();
        chk("rst_in_ready", 32'(in_ready), 1);
        // asynchronous reset in the middle of a cycle drops queued entries
        push(32'h500, 32'h5500, 0);
        push(32'h504, 32'h5504, 0);
        in_valid = 0;
        chk("pre_rst_count", 32'(count_o), 2);
        #3 rst_n = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_count", 32'(count_o), 0);
        chk("midrst_out_instr", out_instr, 32'h13);
        exp_q.delete();
        @(negedge clk) rst_n = 1;
        step();
        // fill to full, blocked fifth push, then in-order drain
        for (int i = 0; i < 4; i++) push(32'(i * 4), 32'h1000 + 32'(i), 0);
        in_pc = 32'h10;
        chk("full_count", 32'(count_o), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        step();
        chk("full_blocked_count", 32'(count_o), 4);
        in_valid  = 0;
        out_ready = 1;
        repeat (4) step();
        chk("drain_count", 32'(count_o), 0);
        chk("empty_out_valid", 32'(out_valid), 0);
        chk("empty_out_instr", out_instr, 32'h13);
        chk("empty_out_pc_hold", out_pc, 32'hC);
        chk("empty_misalign", 32'(out_misalign), 0);
        // streaming push+pop every cycle keeps occupancy at one
        for (int i = 0; i < 20; i++) begin
            push(32'h200 + 32'(i * 4), 32'h2000 + 32'(i), 0);
            chk("stream_count", 32'(count_o), 1);
        end
        in_valid = 0;
        step();
        chk("stream_end_count", 32'(count_o), 0);
        out_ready = 0;
        // flush drops queued entries and the same-cycle push
        for (int i = 0; i < 3; i++) push(32'h40 + 32'(i * 4), 32'h4000 + 32'(i), 0);
        flush_i  = 1;
        in_pc    = 32'h80;
        in_instr = 32'h8080;
        exp_q.delete();
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        step();
        flush_i  = 0;
        in_valid = 0;
        chk("flush_count", 32'(count_o), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        push(32'h100, 32'h0100_0093, 0);
        in_valid = 0;
        chk("post_flush_valid", 32'(out_valid), 1);
        chk("post_flush_pc", out_pc, 32'h100);
        out_ready = 1;
        step();
        out_ready = 0;
        // misalign tagging follows each entry
        push(32'h102, 32'h0600_0013, 1);
        chk("mis_flag", 32'(out_misalign), 1);
        chk("mis_pc", out_pc, 32'h102);
        push(32'h104, 32'h0700_0013, 0);
        in_valid  = 0;
        out_ready = 1;
        step();
        chk("aligned_flag", 32'(out_misalign), 0);
        chk("aligned_pc", out_pc, 32'h104);
        step();
        out_ready = 0;
        // full with pop: pop proceeds, push stays blocked
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 0);
        in_pc     = 32'h400;
        out_ready = 1;
        #1;
        chk("fullpop_in_ready", 32'(in_ready), 0);
        step();
        chk("fullpop_count", 32'(count_o), 3);
        in_valid = 0;
        repeat (3) step();
        chk("final_count", 32'(count_o), 0);
        out_ready = 0;
        repeat (2) step();
        chk("scoreboard_left", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
